// File: rtl/demux_stream_1xn_if.sv
// Bus bundle for the 1-to-NCH stream demux: one valid/ready input stream with
// a select side-band, and NCH one-hot output valids sharing data/last.
interface demux_stream_1xn_if #(
  parameter int DATA_W = 8,
  parameter int NCH    = 4,
  parameter int SEL_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_last;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Environment side: packet source plus per-channel consumers.
  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-NCH packet demultiplexer: the channel is locked on the first
// beat of a packet; packets to a nonexistent channel are dropped and counted.
module demux_stream_1xn #(
  parameter int DATA_W = 8,
  parameter int NCH    = 4,
  parameter int SEL_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_stream_1xn_if.slave   bus,
  output logic                err_sel_o,
  output logic [7:0]          drop_cnt_o
);

  localparam logic [1:0]     S_IDLE = 2'd0;
  localparam logic [1:0]     S_PKT  = 2'd1;
  localparam logic [1:0]     S_DROP = 2'd2;
  localparam logic [SEL_W:0] NCH_L  = (SEL_W + 1)'(NCH);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  lch_q, lch_d;
  logic              full_q, full_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NCH-1:0]    onehot_s;
  logic [SEL_W-1:0]  ld_ch_s;
  logic              sel_ok_s;
  logic              ch_ready_s;
  logic              in_ready_s;
  logic              acc_s;
  logic              xfer_s;
  logic              load_s;
  logic              drop_s;

  assign sel_ok_s = ({1'b0, bus.in_sel} < NCH_L);

  // One-hot decode of the held beat's channel.
  always_comb begin
    onehot_s = '0;
    for (int k = 0; k < NCH; k++) begin
      onehot_s[k] = (ch_q == SEL_W'(k));
    end
  end

  assign ch_ready_s = |(bus.out_ready & onehot_s);
  assign xfer_s     = full_q & ch_ready_s;

  // Input ready: an invalid-select first beat never waits for the register.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_s = sel_ok_s ? (~full_q | ch_ready_s) : 1'b1;
      S_PKT:   in_ready_s = ~full_q | ch_ready_s;
      S_DROP:  in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign acc_s = bus.in_valid & in_ready_s;

  // Packet FSM: decides whether an accepted beat is loaded or discarded.
  always_comb begin
    state_d = state_q;
    lch_d   = lch_q;
    ld_ch_s = lch_q;
    load_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_s && sel_ok_s) begin
          load_s  = 1'b1;
          ld_ch_s = bus.in_sel;
          lch_d   = bus.in_sel;
          state_d = bus.in_last ? S_IDLE : S_PKT;
        end else if (acc_s) begin
          drop_s  = 1'b1;
          state_d = bus.in_last ? S_IDLE : S_DROP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PKT: begin
        if (acc_s) begin
          load_s  = 1'b1;
          state_d = bus.in_last ? S_IDLE : S_PKT;
        end else begin
          state_d = S_PKT;
        end
      end
      S_DROP: begin
        if (acc_s && bus.in_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: a new beat wins over a same-cycle transfer.
  always_comb begin
    full_d = full_q;
    ch_d   = ch_q;
    data_d = data_q;
    last_d = last_q;
    if (load_s) begin
      full_d = 1'b1;
      ch_d   = ld_ch_s;
      data_d = bus.in_data;
      last_d = bus.in_last;
    end else if (xfer_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Drop bookkeeping: sticky error and saturating packet counter.
  always_comb begin
    err_d = err_q | drop_s;
    if (drop_s && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lch_q   <= '0;
      full_q  <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      lch_q   <= lch_d;
      full_q  <= full_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = {NCH{full_q}} & onehot_s;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign err_sel_o     = err_q;
  assign drop_cnt_o    = cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: a 4-channel and a 3-channel instance, each checked
// every cycle against a pending-beat model, plus literal expectations per scenario.
module tb_demux_stream_1xn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_1xn_if #(.DATA_W(8), .NCH(4), .SEL_W(2)) if_a ();
  demux_stream_1xn_if #(.DATA_W(8), .NCH(3), .SEL_W(2)) if_b ();
  logic       err_a, err_b;
  logic [7:0] cnt_a, cnt_b;

  demux_stream_1xn #(.DATA_W(8), .NCH(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .err_sel_o(err_a), .drop_cnt_o(cnt_a));
  demux_stream_1xn #(.DATA_W(8), .NCH(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .err_sel_o(err_b), .drop_cnt_o(cnt_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: at most one undelivered beat per instance, plus packet status.
  int         nch [2];
  bit         m_full [2];
  int         m_ch [2];
  logic [7:0] m_data [2];
  bit         m_last [2];
  bit         m_mid [2];
  bit         m_drop [2];
  int         m_lch [2];
  bit         m_err [2];
  int         m_cnt [2];
  bit         m_acc [2];

  bit         s_valid [2];
  int         s_sel [2];
  logic [7:0] s_data [2];
  bit         s_last [2];
  logic [3:0] s_rdy [2];
  bit         rnd_rdy [2];

  typedef struct { int ch; int data; int last; int cyc; } obs_t;
  obs_t obs_a[$];
  obs_t obs_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_inputs();
    if_a.in_valid  = s_valid[0];
    if_a.in_sel    = 2'(s_sel[0]);
    if_a.in_data   = s_data[0];
    if_a.in_last   = s_last[0];
    if_a.out_ready = s_rdy[0];
    if_b.in_valid  = s_valid[1];
    if_b.in_sel    = 2'(s_sel[1]);
    if_b.in_data   = s_data[1];
    if_b.in_last   = s_last[1];
    if_b.out_ready = s_rdy[1][2:0];
  endtask

  task automatic get_out(input int d, output logic [3:0] ov, output logic [7:0] od,
                         output logic ol, output logic ir, output logic er, output logic [7:0] cn);
    if (d == 0) begin
      ov = if_a.out_valid; od = if_a.out_data; ol = if_a.out_last;
      ir = if_a.in_ready;  er = err_a;         cn = cnt_a;
    end else begin
      ov = {1'b0, if_b.out_valid}; od = if_b.out_data; ol = if_b.out_last;
      ir = if_b.in_ready;          er = err_b;         cn = cnt_b;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0; m_mid[d] = 1'b0; m_drop[d] = 1'b0; m_lch[d] = 0;
      m_err[d] = 1'b0;  m_cnt[d] = 0;    m_acc[d] = 1'b0;
    end
  endtask

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic cycle();
    bit acc_v [2];
    bit xf_v [2];
    for (int d = 0; d < 2; d++) begin
      if (rnd_rdy[d]) s_rdy[d] = 4'($urandom_range(0, 15));
    end
    apply_inputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [3:0] ov;
      logic [7:0] od, cn;
      logic ol, ir, er;
      bit exp_ir;
      logic [3:0] exp_ov;
      get_out(d, ov, od, ol, ir, er, cn);
      exp_ir = m_drop[d] || (!m_mid[d] && s_sel[d] >= nch[d]) || !m_full[d] || s_rdy[d][m_ch[d]];
      exp_ov = m_full[d] ? (4'b0001 << m_ch[d]) : 4'b0000;
      chk($sformatf("in_ready[%0d]", d), 32'(ir), 32'(exp_ir));
      chk($sformatf("out_valid[%0d]", d), 32'(ov), 32'(exp_ov));
      if (m_full[d]) begin
        chk($sformatf("out_data[%0d]", d), 32'(od), 32'(m_data[d]));
        chk($sformatf("out_last[%0d]", d), 32'(ol), 32'(m_last[d]));
      end
      chk($sformatf("err_sel[%0d]", d), 32'(er), 32'(m_err[d]));
      chk($sformatf("drop_cnt[%0d]", d), 32'(cn), 32'(m_cnt[d]));
      acc_v[d] = s_valid[d] && exp_ir;
      xf_v[d]  = m_full[d] && s_rdy[d][m_ch[d]];
      if (rst_n && ((ov & s_rdy[d]) != 4'b0000)) begin
        obs_t o;
        o.ch = 0;
        for (int k = 0; k < 4; k++) if (ov[k]) o.ch = k;
        o.data = int'(od); o.last = int'(ol); o.cyc = cyc;
        if (d == 0) obs_a.push_back(o); else obs_b.push_back(o);
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit loaded;
        loaded = 1'b0;
        m_acc[d] = acc_v[d];
        if (acc_v[d]) begin
          if (m_drop[d]) begin
            m_drop[d] = !s_last[d];
          end else if (!m_mid[d] && s_sel[d] >= nch[d]) begin
            m_err[d] = 1'b1;
            if (m_cnt[d] < 255) m_cnt[d]++;
            m_drop[d] = !s_last[d];
          end else begin
            if (!m_mid[d]) m_lch[d] = s_sel[d];
            m_ch[d] = m_lch[d]; m_data[d] = s_data[d]; m_last[d] = s_last[d];
            m_mid[d] = !s_last[d];
            loaded = 1'b1;
          end
        end
        if (loaded) m_full[d] = 1'b1;
        else if (xf_v[d]) m_full[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input int d, input int sel, input logic [7:0] data, input bit last);
    bit done;
    done = 1'b0;
    s_valid[d] = 1'b1; s_sel[d] = sel; s_data[d] = data; s_last[d] = last;
    for (int i = 0; i < 64 && !done; i++) begin
      cycle();
      done = m_acc[d];
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    s_valid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid[0] = 1'b0; s_valid[1] = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic chk_obs(input string nm, input obs_t o, input int ch, input int data, input int last);
    chk({nm, "_ch"}, 32'(o.ch), 32'(ch));
    chk({nm, "_data"}, 32'(o.data), 32'(data));
    chk({nm, "_last"}, 32'(o.last), 32'(last));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int t_acc;
    nch[0] = 4; nch[1] = 3;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_sel[d] = 0; s_data[d] = 8'h00; s_last[d] = 1'b0;
      s_rdy[d] = 4'hF; rnd_rdy[d] = 1'b0; m_ch[d] = 0; m_data[d] = 8'h00; m_last[d] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    apply_inputs(); #1;
    chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_out_data", 32'(if_a.out_data), 32'd0);
    chk("rst_out_last", 32'(if_a.out_last), 32'd0);
    chk("rst_in_ready", 32'(if_a.in_ready), 32'd1);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);

    // 3-beat packet to ch2; select changes on later beats are ignored.
    obs_a.delete();
    send_beat(0, 2, 8'h11, 1'b0);
    t_acc = cyc;
    send_beat(0, 0, 8'h22, 1'b0);
    send_beat(0, 0, 8'h33, 1'b1);
    idle(3);
    chk("t1_count", 32'(obs_a.size()), 32'd3);
    if (obs_a.size() == 3) begin
      chk_obs("t1_b0", obs_a[0], 2, 'h11, 0);
      chk_obs("t1_b1", obs_a[1], 2, 'h22, 0);
      chk_obs("t1_b2", obs_a[2], 2, 'h33, 1);
      chk("t1_latency", 32'(obs_a[0].cyc), 32'(t_acc));
      chk("t1_gap", 32'(obs_a[2].cyc - obs_a[0].cyc), 32'd2);
    end

    // Back-to-back single-beat packets to every channel.
    obs_a.delete();
    for (int k = 0; k < 4; k++) send_beat(0, k, 8'(8'hA0 + k), 1'b1);
    idle(2);
    chk("t2_count", 32'(obs_a.size()), 32'd4);
    if (obs_a.size() == 4) begin
      for (int k = 0; k < 4; k++) chk_obs($sformatf("t2_b%0d", k), obs_a[k], k, 'hA0 + k, 1);
      chk("t2_gap", 32'(obs_a[3].cyc - obs_a[0].cyc), 32'd3);
    end

    // Stall ch1 for 4 cycles with a second beat waiting.
    obs_a.delete();
    s_rdy[0] = 4'b1101;
    send_beat(0, 1, 8'h55, 1'b0);
    s_valid[0] = 1'b1; s_sel[0] = 3; s_data[0] = 8'h66; s_last[0] = 1'b1;
    repeat (4) begin
      cycle();
      chk("t3_in_ready", 32'(if_a.in_ready), 32'd0);
      chk("t3_out_valid", 32'(if_a.out_valid), 32'b0010);
      chk("t3_out_data", 32'(if_a.out_data), 32'h55);
    end
    s_rdy[0] = 4'hF;
    send_beat(0, 3, 8'h66, 1'b1);
    idle(2);
    chk("t3_count", 32'(obs_a.size()), 32'd2);
    if (obs_a.size() == 2) begin
      chk_obs("t3_b0", obs_a[0], 1, 'h55, 0);
      chk_obs("t3_b1", obs_a[1], 1, 'h66, 1);
    end

    // 3-channel instance: packet to nonexistent ch3 is dropped.
    obs_b.delete();
    s_rdy[1] = 4'h7;
    send_beat(1, 3, 8'hB1, 1'b0);
    send_beat(1, 2, 8'hB2, 1'b1);
    send_beat(1, 0, 8'hC0, 1'b1);
    idle(2);
    chk("t4_err", 32'(err_b), 32'd1);
    chk("t4_cnt", 32'(cnt_b), 32'd1);
    chk("t4_count", 32'(obs_b.size()), 32'd1);
    if (obs_b.size() == 1) chk_obs("t4_b0", obs_b[0], 0, 'hC0, 1);

    // Saturate the drop counter.
    for (int k = 0; k < 256; k++) send_beat(1, 3, 8'(k), 1'b1);
    idle(1);
    chk("t5_cnt", 32'(cnt_b), 32'd255);
    chk("t5_err", 32'(err_b), 32'd1);
    chk("t5_model_cnt", 32'(m_cnt[1]), 32'd255);

    // Reset mid-packet; next beat is a fresh first beat.
    obs_a.delete();
    send_beat(0, 1, 8'h31, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    apply_inputs(); #1;
    chk("t6_out_valid", 32'(if_a.out_valid), 32'd0);
    chk("t6_out_data", 32'(if_a.out_data), 32'd0);
    chk("t6_out_last", 32'(if_a.out_last), 32'd0);
    chk("t6_in_ready", 32'(if_a.in_ready), 32'd1);
    chk("t6_err_b", 32'(err_b), 32'd0);
    chk("t6_cnt_b", 32'(cnt_b), 32'd0);
    send_beat(0, 3, 8'h99, 1'b1);
    idle(2);
    chk("t6_count", 32'(obs_a.size()), 32'd1);
    if (obs_a.size() == 1) chk_obs("t6_b0", obs_a[0], 3, 'h99, 1);

    // Random packets with random consumer backpressure on both instances.
    rnd_rdy[0] = 1'b1; rnd_rdy[1] = 1'b1;
    for (int p = 0; p < 300; p++) begin
      int d, len, sel;
      d = $urandom_range(0, 1);
      len = $urandom_range(1, 4);
      sel = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        send_beat(d, (b == 0) ? sel : int'($urandom_range(0, 3)), 8'($urandom), b == len - 1);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rnd_rdy[0] = 1'b0; rnd_rdy[1] = 1'b0;
    s_rdy[0] = 4'hF; s_rdy[1] = 4'h7;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_1xn.md
# demux_stream_1xn

Registered 1-to-NCH stream demultiplexer, successor to the combinational 1x4 demux. Routes packets from a single valid/ready input stream to one of NCH output channels chosen by a select field sampled on the first beat of each packet and locked until the last beat. A one-beat output register gives 1-cycle latency at full throughput. Packets addressed to a nonexistent channel are dropped and counted. Sits between a packet source and per-channel consumers in the datapath.

## Interface
- DATA_W, 8, payload width in bits
- NCH, 4, number of output channels (2..2**SEL_W)
- SEL_W, 2, select field width
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- in_data  input  DATA_W  input payload
- in_sel  input  SEL_W  destination channel; sampled only on first beat of a packet
- in_last  input  1  final beat of packet
- out_valid  output  NCH  one-hot; bit k = beat present for channel k
- out_ready  input  NCH  per-channel consumer ready
- out_data  output  DATA_W  payload, shared by all channels
- out_last  output  1  final-beat flag, shared
- err_sel  output  1  sticky: set when a packet with in_sel >= NCH was dropped
- drop_cnt  output  8  count of dropped packets, saturates at 255

## Operation
- Accept: acc = in_valid & in_ready. Output transfer: xfer = out_valid[ch] & out_ready[ch].
- Output register: full, ch, out_data, out_last. out_valid[k] = full & (ch == k); all other bits 0.
- Packet FSM, states IDLE, PKT, DROP:
  - IDLE: on acc with in_sel < NCH: lock lch = in_sel, load register; next PKT unless in_last (stay IDLE).
  - IDLE: on acc with in_sel >= NCH: beat discarded, err_sel <= 1, drop_cnt++ (saturating); next DROP unless in_last (stay IDLE).
  - PKT: on acc, load register with channel lch (in_sel ignored); on in_last, next IDLE.
  - DROP: in_ready = 1; beats discarded; on acc & in_last, next IDLE. No count per beat.
- in_ready (IDLE/PKT) = ~full | out_ready[ch]; one beat per cycle when consumer is ready. in_ready does not depend on in_valid. In IDLE, an invalid-sel first beat is discarded without waiting for the register to drain (in_ready = 1 when in_sel >= NCH).
- Register update: if acc (non-drop) load full=1, data, ch, last; else if xfer clear full. Load and xfer in same cycle: new beat replaces, full stays 1.
- Data on out_data/out_last held stable while full & ~out_ready[ch]. A consumer never sees out_valid drop without a transfer.
- Packets to different channels are delivered strictly in input order; a stalled channel blocks all channels (no reordering).
- err_sel clears only on reset.

## Timing
- Reset (rst_n low at clk edge): full=0, out_valid=0, out_data=0, out_last=0, state IDLE, lch=0, err_sel=0, drop_cnt=0. in_ready=1 in the cycle after reset.
- Reset mid-packet: partial packet abandoned; the next accepted beat is treated as a first beat.
- Latency: beat accepted at edge t appears on outputs after edge t, transferable at edge t+1.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- Single-beat packet (in_last on first beat): FSM stays IDLE; next beat resamples in_sel.
- drop_cnt at 255 holds 255; err_sel remains 1.

## Test plan
- Reset, then 3-beat packet sel=2 data 0x11,0x22,0x33, in_sel changed to 0 on beats 2-3, all out_ready=1 -> out_valid=4'b0100 for 3 consecutive cycles with 0x11,0x22,0x33, out_last on 0x33 only, 1-cycle latency.
- Back-to-back single-beat packets sel=0,1,2,3 data 0xA0..0xA3 -> out_valid one-hot 0001,0010,0100,1000 on consecutive cycles, no bubbles.
- Packet to ch1 with out_ready[1]=0 for 4 cycles -> out_valid=4'b0010 and out_data held constant, in_ready=0; second input beat not lost; released when out_ready[1]=1.
- NCH=3, packet sel=3 of 2 beats then packet sel=0 -> first packet never appears, err_sel=1, drop_cnt=1, second packet delivered on ch0.
- 256 invalid-sel single-beat packets -> drop_cnt=255 saturated, err_sel=1.
- rst_n low for 1 cycle after beat 1 of a 3-beat sel=1 packet -> all outputs 0; following beat with sel=3 routes to ch3.
